// File: rtl/gray_ptr_sync_pkg.sv
// Shared types and helpers for the Gray pointer synchronizer.
// Holds the FSM state enum, error-counter width and bit helpers.
package sync_pkg;

    localparam int ERR_CNT_W = 8;

    typedef enum logic {
        SYNC_WARMUP,
        SYNC_RUN
    } sync_state_t;

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = '0;
        for (int i = 0; i < 32; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/gray_ptr_sync_if.sv
// Pointer-sync bundle: source Gray pointer in, decoded view out.
// master drives gray_in/clr_err; slave (the synchronizer) drives the rest.
interface gray_ptr_sync_if #(
    parameter int ADDR_WIDTH = 6
);
    import sync_pkg::*;

    localparam int PTR_W = ADDR_WIDTH + 1;

    logic [PTR_W-1:0]     gray_in;
    logic                 clr_err;
    logic [PTR_W-1:0]     sync_gray;
    logic [PTR_W-1:0]     bin_out;
    logic [PTR_W-1:0]     delta;
    logic                 ptr_chg;
    logic                 valid;
    logic                 sync_err;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output gray_in, clr_err,
        input  sync_gray, bin_out, delta, ptr_chg,
        input  valid, sync_err, err_cnt
    );

    modport slave (
        input  gray_in, clr_err,
        output sync_gray, bin_out, delta, ptr_chg,
        output valid, sync_err, err_cnt
    );

endinterface

// File: rtl/gray_ptr_sync_chain.sv
// Plain flop chain carrying an async Gray pointer into clk.
// Ports: clk, rst_n (async low), d (async input), q (last stage).
module sync_chain #(
    parameter int PTR_W  = 7,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PTR_W-1:0] d,
    output logic [PTR_W-1:0] q
);

    logic [PTR_W-1:0] stage [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/gray_ptr_sync.sv
// Gray pointer synchronizer: chain, registered decode, delta, warm-up.
// Ports: clk, rst_n (async low), bus (slave: gray_in/clr_err in,
// sync_gray/bin_out/delta/ptr_chg/valid/sync_err/err_cnt out).
// Optional Gray-step error monitor enabled by GRAY_SYNC_ERR_CHECK_EN.
module gray_ptr_sync
    import sync_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int STAGES     = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    gray_ptr_sync_if.slave bus
);

    localparam int PTR_W = ADDR_WIDTH + 1;

    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $error("gray_ptr_sync: STAGES must be 2..4");
    end

    logic [PTR_W-1:0] sync_gray;
    logic [PTR_W-1:0] nb;
    logic [PTR_W-1:0] bin_q;
    logic [PTR_W-1:0] delta_q;
    logic             chg_q;
    logic             run;

    sync_state_t state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;

    sync_chain #(
        .PTR_W  (PTR_W),
        .STAGES (STAGES)
    ) u_chain (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.gray_in),
        .q     (sync_gray)
    );

    assign nb  = PTR_W'(gray2bin(32'(sync_gray)));
    assign run = (state == SYNC_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SYNC_WARMUP;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Warm-up lasts STAGES+1 edges: enough for the chain and decode
    // register to hold data sampled after reset release.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            SYNC_WARMUP: begin
                if (cnt == 3'(STAGES)) begin
                    state_nxt = SYNC_RUN;
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
            end
            SYNC_RUN: begin
                state_nxt = SYNC_RUN;
            end
            default: begin
                state_nxt = SYNC_WARMUP;
            end
        endcase
    end

    // bin_out tracks during warm-up so delta starts from a sane base.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q   <= '0;
            delta_q <= '0;
            chg_q   <= 1'b0;
        end else begin
            bin_q   <= nb;
            delta_q <= run ? (nb - bin_q) : '0;
            chg_q   <= run && (nb != bin_q);
        end
    end

    assign bus.sync_gray = sync_gray;
    assign bus.bin_out   = bin_q;
    assign bus.delta     = delta_q;
    assign bus.ptr_chg   = chg_q;
    assign bus.valid     = run;

`ifdef GRAY_SYNC_ERR_CHECK_EN
    logic [PTR_W-1:0]     prev_gray;
    logic                 step_err;
    logic                 err_q;
    logic [ERR_CNT_W-1:0] ecnt_q;

    assign step_err = run &&
        (popcount(32'(sync_gray ^ prev_gray)) > 1);

    // A fresh error outranks a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_gray <= '0;
            err_q     <= 1'b0;
            ecnt_q    <= '0;
        end else begin
            prev_gray <= sync_gray;
            if (step_err) begin
                err_q <= 1'b1;
                if (bus.clr_err) begin
                    ecnt_q <= ERR_CNT_W'(1);
                end else if (ecnt_q != '1) begin
                    ecnt_q <= ecnt_q + ERR_CNT_W'(1);
                end
            end else if (bus.clr_err) begin
                err_q  <= 1'b0;
                ecnt_q <= '0;
            end
        end
    end

    assign bus.sync_err = err_q;
    assign bus.err_cnt  = ecnt_q;
`else
    assign bus.sync_err = 1'b0;
    assign bus.err_cnt  = '0;
`endif

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Self-checking bench for gray_ptr_sync (ADDR_WIDTH=6, STAGES=2).
// Reference model works from the history of sampled gray_in values.
module tb_gray_ptr_sync;

    localparam int AW     = 6;
    localparam int STAGES = 2;
    localparam int PW     = AW + 1;
`ifdef GRAY_SYNC_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;

    gray_ptr_sync_if #(.ADDR_WIDTH(AW)) bus ();

    gray_ptr_sync #(
        .ADDR_WIDTH (AW),
        .STAGES     (STAGES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model state
    logic [PW-1:0] hist[$];
    int            n;
    bit            exp_err;
    int            exp_cnt;

    function automatic logic [PW-1:0] to_gray(input int b);
        logic [PW-1:0] v;
        v = PW'(b);
        return v ^ (v >> 1);
    endfunction

    function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b = '0;
        for (int i = 0; i < PW; i++) b = b ^ (g >> i);
        return b;
    endfunction

    // sync_gray expected after k edges since reset release
    function automatic logic [PW-1:0] sync_at(input int k);
        if (k < STAGES) return '0;
        return hist[k-STAGES];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        n       = 0;
        exp_err = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".sync_gray"}, 32'(bus.sync_gray), 0);
        chk({tag, ".bin_out"},   32'(bus.bin_out),   0);
        chk({tag, ".delta"},     32'(bus.delta),     0);
        chk({tag, ".ptr_chg"},   32'(bus.ptr_chg),   0);
        chk({tag, ".valid"},     32'(bus.valid),     0);
        chk({tag, ".sync_err"},  32'(bus.sync_err),  0);
        chk({tag, ".err_cnt"},   32'(bus.err_cnt),   0);
    endtask

    task automatic tick(input string tag, input logic [PW-1:0] g,
                        input bit clr);
        logic [PW-1:0] eb, ebp, ed;
        bit            rune, ev, e;
        bus.gray_in = g;
        bus.clr_err = clr;
        @(posedge clk);
        hist.push_back(g);
        n++;
        eb   = g2b(sync_at(n-1));
        ebp  = g2b(sync_at(n-2));
        rune = (n >= STAGES + 2);
        ev   = (n >= STAGES + 1);
        ed   = rune ? PW'(eb - ebp) : '0;
        e    = ERR_EN && rune &&
               ($countones(sync_at(n-1) ^ sync_at(n-2)) > 1);
        if (e) begin
            exp_err = 1'b1;
            exp_cnt = clr ? 1 : ((exp_cnt < 255) ? exp_cnt + 1 : 255);
        end else if (clr && ERR_EN) begin
            exp_err = 1'b0;
            exp_cnt = 0;
        end
        #1;
        chk({tag, ".sync_gray"}, 32'(bus.sync_gray), 32'(sync_at(n)));
        chk({tag, ".bin_out"},   32'(bus.bin_out),   32'(eb));
        chk({tag, ".delta"},     32'(bus.delta),     32'(ed));
        chk({tag, ".ptr_chg"},   32'(bus.ptr_chg),   32'(rune && eb != ebp));
        chk({tag, ".valid"},     32'(bus.valid),     32'(ev));
        chk({tag, ".sync_err"},  32'(bus.sync_err),  32'(exp_err));
        chk({tag, ".err_cnt"},   32'(bus.err_cnt),   32'(exp_cnt));
    endtask

    int b;

    initial begin
        rst_n       = 1'b0;
        bus.gray_in = '0;
        bus.clr_err = 1'b0;
        model_reset();
        #12;
        chk_zero("reset");
        rst_n = 1'b1;

        // warm-up with gray_in = 0
        for (int i = 0; i < 4; i++) tick("warmup", '0, 1'b0);

        // single step 0 -> 1 then hold
        for (int i = 0; i < 4; i++) tick("step1", to_gray(1), 1'b0);

        // walk up to bin 127, then wrap to 0
        for (int k = 2; k < 128; k++) tick("walk", to_gray(k), 1'b0);
        for (int i = 0; i < 4; i++) tick("wrap", to_gray(0), 1'b0);

        // randomized Gray walk with occasional jumps and clears
        b = 0;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) == 0)
                b = int'($urandom_range(0, 127));
            else
                b = (b + int'($urandom_range(0, 1))) % 128;
            tick("rand", to_gray(b), ($urandom_range(0, 15) == 0));
        end

        // multi-bit jump 00 -> 03, then clear
        for (int i = 0; i < 4; i++) tick("jz", 7'h00, 1'b0);
        for (int i = 0; i < 4; i++) tick("jump", 7'h03, 1'b0);
        tick("clr", 7'h03, 1'b1);
        for (int i = 0; i < 2; i++) tick("hold", 7'h03, 1'b0);

        // clear coincides with a fresh 03 -> 00 error
        tick("cj0", 7'h00, 1'b0);
        tick("cj1", 7'h00, 1'b0);
        tick("cj2", 7'h00, 1'b1);
        tick("cj3", 7'h00, 1'b0);

        // 300 back-to-back errors saturate the counter
        for (int i = 0; i < 300; i++)
            tick("sat", (i % 2 == 0) ? 7'h03 : 7'h00, 1'b0);
        for (int i = 0; i < 4; i++) tick("sat_h", 7'h00, 1'b0);

        // walk to bin 45, then reset mid-stream
        for (int k = 1; k <= 45; k++) tick("to45", to_gray(k), 1'b0);
        for (int i = 0; i < 3; i++) tick("h45", to_gray(45), 1'b0);
        chk("pre_rst.bin_out", 32'(bus.bin_out), 45);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_zero("async_rst");
        bus.gray_in = to_gray(77);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick("rewarm", to_gray(77), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
